nvl2_countdown_timer: RTL and testbench

//  Microwave cook-time countdown timer: MM:SS in BCD, loaded digit-by-digit from the keypad.

---
 rtl/nvl2_countdown_timer.sv | 172 +++++++++++++++++
 tb/tb_nvl2_countdown_timer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/nvl2_countdown_timer.sv
// nvl2_countdown_timer: microwave cook-time countdown in BCD (MM:SS).
// The keypad loads digits by shifting them in from the right. The timer counts down
// once per second while enable (magnetron Q from nvl2_controle) is high.
// Optional feature macro: NVL2_ALARM_EN. When it is defined, the design holds an
// expiry alarm for ALARM_SECS seconds. Without it, alarm is tied to 0.
module nvl2_countdown_timer #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int ALARM_SECS    = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clearn,
  input  logic       digit_vld,
  input  logic [3:0] digit,
  input  logic       enable,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       timer_done,
  output logic       alarm
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_EXPIRED} state_t;

  state_t        state_q, state_d;
  logic [3:0]    mt_q, mt_d, mo_q, mo_d, st_q, st_d, so_q, so_d;
  logic [PW-1:0] presc_q, presc_d;

  logic       time_nz, entry_ok, dec_zero;
  logic [3:0] dec_mt, dec_mo, dec_st, dec_so;

  assign time_nz  = |{mt_q, mo_q, st_q, so_q};
  assign entry_ok = digit_vld && !enable && (digit <= 4'd9);
  assign dec_zero = ~|{dec_mt, dec_mo, dec_st, dec_so};

  // BCD one-second decrement of the current time. It is only consumed when the time is nonzero.
  always_comb begin
    dec_mt = mt_q;
    dec_mo = mo_q;
    dec_st = st_q;
    dec_so = so_q;
    if (so_q != 4'd0) begin
      dec_so = so_q - 4'd1;
    end else if (st_q != 4'd0) begin
      dec_st = st_q - 4'd1;
      dec_so = 4'd9;
    end else begin
      dec_st = 4'd5;
      dec_so = 4'd9;
      if (mo_q != 4'd0) begin
        dec_mo = mo_q - 4'd1;
      end else begin
        dec_mo = 4'd9;
        dec_mt = mt_q - 4'd1;
      end
    end
  end

  // Next state: clear > digit entry > prescaled countdown. A pause keeps the partial second.
  always_comb begin
    state_d = state_q;
    mt_d    = mt_q;
    mo_d    = mo_q;
    st_d    = st_q;
    so_d    = so_q;
    presc_d = presc_q;
    if (!clearn) begin
      state_d = S_IDLE;
      mt_d    = 4'd0;
      mo_d    = 4'd0;
      st_d    = 4'd0;
      so_d    = 4'd0;
      presc_d = '0;
    end else if (entry_ok) begin
      state_d = S_IDLE;
      mt_d    = mo_q;
      mo_d    = st_q;
      st_d    = so_q;
      so_d    = digit;
      presc_d = '0;
    end else if ((state_q != S_EXPIRED) && enable && time_nz) begin
      // The IDLE->RUN cycle counts too, so each enabled cycle advances the prescaler.
      state_d = S_RUN;
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        mt_d    = dec_mt;
        mo_d    = dec_mo;
        st_d    = dec_st;
        so_d    = dec_so;
        if (dec_zero) state_d = S_EXPIRED;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else if ((state_q == S_RUN) && !enable) begin
      state_d = S_IDLE;
    end
  end

  // Time digits, prescaler and FSM state registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      mt_q    <= 4'd0;
      mo_q    <= 4'd0;
      st_q    <= 4'd0;
      so_q    <= 4'd0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      mt_q    <= mt_d;
      mo_q    <= mo_d;
      st_q    <= st_d;
      so_q    <= so_d;
      presc_q <= presc_d;
    end
  end

  assign min_tens   = mt_q;
  assign min_ones   = mo_q;
  assign sec_tens   = st_q;
  assign sec_ones   = so_q;
  assign timer_done = ~time_nz;

`ifdef NVL2_ALARM_EN
  localparam int ALARM_CYC = ALARM_SECS * TICKS_PER_SEC;
  localparam int AW        = (ALARM_CYC > 2) ? $clog2(ALARM_CYC) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CYC - 1);

  logic          alarm_q, alarm_d, expire_evt;
  logic [AW-1:0] acnt_q, acnt_d;

  assign expire_evt = (state_d == S_EXPIRED) && (state_q != S_EXPIRED);

  // Alarm is held for ALARM_CYC cycles after expiry. It ignores enable. Clear or a new entry cuts it short.
  always_comb begin
    alarm_d = alarm_q;
    acnt_d  = acnt_q;
    if (!clearn || entry_ok) begin
      alarm_d = 1'b0;
      acnt_d  = '0;
    end else if (expire_evt) begin
      alarm_d = 1'b1;
      acnt_d  = ALARM_LAST;
    end else if (alarm_q) begin
      if (acnt_q == '0) alarm_d = 1'b0;
      else              acnt_d  = acnt_q - 1'b1;
    end
  end

  // Alarm registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      alarm_q <= 1'b0;
      acnt_q  <= '0;
    end else begin
      alarm_q <= alarm_d;
      acnt_q  <= acnt_d;
    end
  end

  assign alarm = alarm_q;
`else
  logic unused_alarm_cfg;
  assign unused_alarm_cfg = (ALARM_SECS != 0);
  assign alarm            = 1'b0;
`endif

endmodule

// File: tb/tb_nvl2_countdown_timer.sv
// Testbench for nvl2_countdown_timer. It runs a directed vector table, then
// hand-written reset sequences, then random stimulus checked against a
// minutes/seconds reference model.
module tb_nvl2_countdown_timer;
  localparam int T = 4;
  localparam int A = 2;

  logic       clk = 1'b0;
  logic       resetn, clearn, digit_vld, enable;
  logic [3:0] digit;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       timer_done, alarm;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nvl2_countdown_timer #(.TICKS_PER_SEC(T), .ALARM_SECS(A)) dut (
    .clk(clk), .resetn(resetn), .clearn(clearn), .digit_vld(digit_vld),
    .digit(digit), .enable(enable), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .timer_done(timer_done), .alarm(alarm)
  );

  // Reference model: the time is held as plain minutes/seconds integers.
  int m_min, m_sec, m_presc, m_alarm_left;
  bit m_expired;

  function automatic bit alarm_on();
`ifdef NVL2_ALARM_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] model_bcd();
    logic [15:0] r;
    r = {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    return r;
  endfunction

  task automatic model_step(input bit r, input bit c, input bit v, input int d, input bit e);
    bit entry, expire;
    int n;
    expire = 1'b0;
    if (!r) begin
      m_min = 0; m_sec = 0; m_presc = 0; m_expired = 0; m_alarm_left = 0;
      return;
    end
    entry = v && !e && (d <= 9);
    if (!c) begin
      m_min = 0; m_sec = 0; m_presc = 0; m_expired = 0;
    end else if (entry) begin
      n = ((m_min * 100 + m_sec) * 10 + d) % 10000;
      m_min = n / 100; m_sec = n % 100; m_presc = 0; m_expired = 0;
    end else if (!m_expired && e && (m_min != 0 || m_sec != 0)) begin
      m_presc++;
      if (m_presc == T) begin
        m_presc = 0;
        if (m_sec > 0) m_sec--;
        else begin m_min--; m_sec = 59; end
        if (m_min == 0 && m_sec == 0) begin m_expired = 1; expire = 1; end
      end
    end
    if (!c || entry)  m_alarm_left = 0;
    else if (expire)  m_alarm_left = alarm_on() ? A * T : 0;
    else if (m_alarm_left > 0) m_alarm_left--;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_model(input string nm);
    check({nm, "_time"}, 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'(model_bcd()));
    check({nm, "_done"}, 32'(timer_done), 32'(m_min == 0 && m_sec == 0));
    check({nm, "_alarm"}, 32'(alarm), 32'(m_alarm_left > 0));
  endtask

  task automatic cycle(input bit r, input bit c, input bit v, input int d, input bit e);
    resetn = r; clearn = c; digit_vld = v; digit = d[3:0]; enable = e;
    @(posedge clk);
    #1;
    model_step(r, c, v, d, e);
  endtask

  typedef struct {
    bit          c;
    bit          v;
    int          d;
    bit          e;
    logic [15:0] t;
    bit          al;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input bit c, input bit v, input int d, input bit e,
                     input logic [15:0] t, input bit al);
    vec_t x;
    x.c = c; x.v = v; x.d = d; x.e = e; x.t = t; x.al = al;
    tbl.push_back(x);
  endtask

  task automatic ent(input int d, input logic [15:0] t);
    add(1, 1, d, 0, t, 0);
  endtask

  task automatic run(input int n, input logic [15:0] t);
    for (int k = 0; k < n; k++) add(1, 0, 0, 1, t, 0);
  endtask

  initial begin
    bit en_r;
    int d;
    resetn = 1'b0; clearn = 1'b1; digit_vld = 1'b0; digit = 4'd0; enable = 1'b0;

    // Reset wins over a simultaneous digit entry.
    cycle(0, 1, 1, 5, 0);
    check("reset_time", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'h0);
    check("reset_done", 32'(timer_done), 32'h1);
    check("reset_alarm", 32'(alarm), 32'h0);

    // Entry, then an out-of-range digit is ignored.
    ent(1, 16'h0001); ent(3, 16'h0013); ent(0, 16'h0130); ent(12, 16'h0130);
    // Seconds borrow from minutes: 01:00 -> 00:59.
    add(0, 0, 0, 0, 16'h0000, 0);
    ent(1, 16'h0001); ent(0, 16'h0010); ent(0, 16'h0100);
    run(3, 16'h0100); run(1, 16'h0059);
    add(1, 0, 0, 0, 16'h0059, 0);
    // Minutes tens borrow: 10:00 -> 09:59.
    ent(1, 16'h0591); ent(0, 16'h5910); ent(0, 16'h9100); ent(0, 16'h1000);
    run(3, 16'h1000); run(1, 16'h0959);
    add(1, 0, 0, 0, 16'h0959, 0);
    // Expiry at 00:00. The alarm is held for exactly A*T cycles, and further enable does nothing.
    add(0, 0, 0, 0, 16'h0000, 0);
    ent(2, 16'h0002);
    run(3, 16'h0002); run(4, 16'h0001);
    add(1, 0, 0, 1, 16'h0000, 1);
    for (int k = 0; k < 7; k++) add(1, 0, 0, 1, 16'h0000, 1);
    add(1, 0, 0, 1, 16'h0000, 0);
    // Pause keeps the partial second. An entry during enable is ignored.
    add(0, 0, 0, 0, 16'h0000, 0);
    ent(5, 16'h0005);
    run(2, 16'h0005);
    for (int k = 0; k < 3; k++) add(1, 0, 0, 0, 16'h0005, 0);
    add(1, 0, 0, 1, 16'h0005, 0);
    add(1, 0, 0, 1, 16'h0004, 0);
    add(1, 1, 7, 1, 16'h0004, 0);
    // A clear with a simultaneous digit mid-RUN aborts. The prescaler restarts from 0.
    add(1, 0, 0, 1, 16'h0004, 0);
    add(0, 1, 3, 1, 16'h0000, 0);
    add(1, 0, 0, 1, 16'h0000, 0);
    ent(3, 16'h0003);
    run(3, 16'h0003); run(1, 16'h0002);
    // 99:99 is a legal start value.
    add(0, 0, 0, 0, 16'h0000, 0);
    ent(9, 16'h0009); ent(9, 16'h0099); ent(9, 16'h0999); ent(9, 16'h9999);
    run(3, 16'h9999); run(1, 16'h9998);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(1, tbl[i].c, tbl[i].v, tbl[i].d, tbl[i].e);
      check($sformatf("vec%0d_time", i), 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'(tbl[i].t));
      check($sformatf("vec%0d_done", i), 32'(timer_done), 32'(tbl[i].t == 16'h0));
      check($sformatf("vec%0d_alarm", i), 32'(alarm), 32'(tbl[i].al & alarm_on()));
    end

    // A reset mid-RUN drops the partial second. A fresh 00:01 then needs a full T cycles.
    cycle(1, 0, 0, 0, 0);
    cycle(1, 1, 1, 3, 0);
    cycle(1, 1, 0, 0, 1);
    cycle(1, 1, 0, 0, 1);
    cycle(0, 1, 0, 0, 1);
    check("midrun_reset_time", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'h0);
    check_model("midrun_reset");
    cycle(1, 1, 1, 1, 0);
    for (int k = 0; k < T - 1; k++) cycle(1, 1, 0, 0, 1);
    check("fresh_sec_pending", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'h0001);
    cycle(1, 1, 0, 0, 1);
    check("fresh_sec_expired", 32'({min_tens, min_ones, sec_tens, sec_ones}), 32'h0);
    check_model("fresh_sec");

    // Random stimulus against the reference model.
    en_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) en_r = ~en_r;
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 11)) : int'($urandom_range(0, 1));
      cycle($urandom_range(0, 199) != 0, $urandom_range(0, 39) != 0,
            $urandom_range(0, 5) == 0, d, en_r);
      check_model($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
